// File: rtl/avr_intc.sv
// ---------------------------------------------------------------------------
// avr_intc -- vectored, prioritised interrupt controller and entry sequencer
// for the AVR8 microcode core.
//
// NIRQ maskable request channels, each either rising-edge captured or level
// sensitive (EDGE_MASK). Channel 0 is additionally driven by a programmable
// millisecond-quantum timer (the old timeslice interrupt). When an enabled
// request is seen at an instruction boundary with SREG.I set, the controller
// takes the RAM bus, pushes the return PC (low byte first), and then has the
// CPU load the vector PC and clear SREG.I.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   irq[NIRQ]         request lines (synchronous to clock)
//   mask_we/mask_wd   enable-mask write port
//   quantum_we/_wd    timeslice limit write port (0 disables the timer)
//   tick              one-cycle 1 ms strobe
//   boundary, ie      CPU at instruction boundary / SREG.I
//   pc_in, sp         return address and stack pointer to use for the push
//   busy              controller owns the bus, CPU must hold
//   address, wb, w    RAM push port
//   sp_dec            CPU decrements SP at the next edge
//   pc_load, pc_vec   CPU loads pc_vec at the next edge
//   clr_i             CPU clears SREG.I at the next edge
//   pending           per-channel pending status before masking
//   active_id         channel most recently taken
// ---------------------------------------------------------------------------
module avr_intc #(
    parameter int              NIRQ        = 8,
    parameter int              PCW         = 16,
    parameter int              VEC_BASE    = 2,
    parameter int              VEC_STRIDE  = 2,
    parameter logic [NIRQ-1:0] EDGE_MASK   = NIRQ'(8'hFE),
    parameter logic [NIRQ-1:0] MASK_RST    = NIRQ'(8'h01),
    parameter logic [7:0]      QUANTUM_RST = 8'd10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wd,
    input  logic            quantum_we,
    input  logic [7:0]      quantum_wd,
    input  logic            tick,
    input  logic            boundary,
    input  logic            ie,
    input  logic [PCW-1:0]  pc_in,
    input  logic [15:0]     sp,
    output logic            busy,
    output logic [15:0]     address,
    output logic [7:0]      wb,
    output logic            w,
    output logic            sp_dec,
    output logic            pc_load,
    output logic [PCW-1:0]  pc_vec,
    output logic            clr_i,
    output logic [NIRQ-1:0] pending,
    output logic [3:0]      active_id
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PUSH_L = 2'd1;
    localparam logic [1:0] ST_PUSH_H = 2'd2;
    localparam logic [1:0] ST_VECT   = 2'd3;

    logic [1:0]      state_reg;
    logic [NIRQ-1:0] irq_d_reg;
    logic [NIRQ-1:0] edge_pend_reg;
    logic [NIRQ-1:0] edge_pend_next;
    logic [NIRQ-1:0] mask_reg;
    logic [7:0]      quantum_reg;
    logic [7:0]      counter_reg;
    logic [PCW-1:0]  pc_save_reg;
    logic [15:0]     sp_save_reg;
    logic [15:0]     address_reg;
    logic [7:0]      wb_reg;
    logic            w_reg;
    logic            sp_dec_reg;
    logic            pc_load_reg;
    logic            clr_i_reg;
    logic [PCW-1:0]  pc_vec_reg;
    logic [3:0]      active_id_reg;

    logic            src0;
    logic            take;
    logic [3:0]      take_id;
    logic [NIRQ-1:0] req;
    logic [NIRQ-1:0] rise;
    logic            in_push_l;
    logic [PCW-1:0]  pc_vec_next;
    logic [7:0]      wb_hi;

    // Timer request: the limit of 0 means "timer off", so it never fires.
    assign src0 = (quantum_reg != 8'd0) && (counter_reg >= quantum_reg);

    assign rise      = irq & ~irq_d_reg;
    assign in_push_l = (state_reg == ST_PUSH_L);

    // Edge channels hold a captured flag until their own entry sequence
    // reaches the high-byte push; a new edge in that same cycle is kept.
    // Level channels simply reflect the live line.
    for (genvar gi = 0; gi < NIRQ; gi++) begin : g_chan
        logic clr_this;
        assign clr_this = in_push_l && (active_id_reg == 4'(gi));
        assign edge_pend_next[gi] = EDGE_MASK[gi]
                                  ? (rise[gi] | (edge_pend_reg[gi] & ~clr_this))
                                  : 1'b0;
        assign pending[gi] = (EDGE_MASK[gi] ? edge_pend_reg[gi] : irq[gi])
                           | ((gi == 0) ? src0 : 1'b0);
    end

    assign req = pending & mask_reg;

    // Lowest-numbered enabled request has priority: scan downwards so the
    // last hit (lowest index) is the one kept.
    always_comb begin
        take_id = 4'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                take_id = 4'(i);
            end
        end
    end

    assign take = (state_reg == ST_IDLE) && boundary && ie && (|req);
    assign busy = take || (state_reg != ST_IDLE);

    // Vector address wraps modulo the PC width.
    assign pc_vec_next = PCW'(VEC_BASE) + PCW'(VEC_STRIDE) * PCW'(active_id_reg);
    // High part of the return PC, zero-extended to a byte.
    assign wb_hi = 8'(pc_save_reg >> 8);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            irq_d_reg     <= '0;
            edge_pend_reg <= '0;
            mask_reg      <= MASK_RST;
            quantum_reg   <= QUANTUM_RST;
            counter_reg   <= 8'd0;
            pc_save_reg   <= '0;
            sp_save_reg   <= 16'd0;
            address_reg   <= 16'd0;
            wb_reg        <= 8'd0;
            w_reg         <= 1'b0;
            sp_dec_reg    <= 1'b0;
            pc_load_reg   <= 1'b0;
            clr_i_reg     <= 1'b0;
            pc_vec_reg    <= '0;
            active_id_reg <= 4'd0;
        end else begin
            irq_d_reg     <= irq;
            edge_pend_reg <= edge_pend_next;

            if (mask_we) begin
                mask_reg <= mask_wd;
            end
            if (quantum_we) begin
                quantum_reg <= quantum_wd;
            end

            // The quantum only runs while the CPU is interruptible and idle;
            // servicing channel 0 or reprogramming the limit restarts it.
            if (quantum_we || (in_push_l && active_id_reg == 4'd0)) begin
                counter_reg <= 8'd0;
            end else if (tick && ie && state_reg == ST_IDLE && counter_reg != 8'hFF) begin
                counter_reg <= counter_reg + 8'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (take) begin
                        state_reg     <= ST_PUSH_L;
                        active_id_reg <= take_id;
                        pc_save_reg   <= pc_in;
                        sp_save_reg   <= sp;
                        address_reg   <= sp;
                        wb_reg        <= pc_in[7:0];
                        w_reg         <= 1'b1;
                        sp_dec_reg    <= 1'b1;
                    end
                end
                ST_PUSH_L: begin
                    state_reg   <= ST_PUSH_H;
                    address_reg <= sp_save_reg - 16'd1;
                    wb_reg      <= wb_hi;
                    w_reg       <= 1'b1;
                    sp_dec_reg  <= 1'b1;
                end
                ST_PUSH_H: begin
                    state_reg   <= ST_VECT;
                    w_reg       <= 1'b0;
                    sp_dec_reg  <= 1'b0;
                    pc_load_reg <= 1'b1;
                    clr_i_reg   <= 1'b1;
                    pc_vec_reg  <= pc_vec_next;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    pc_load_reg <= 1'b0;
                    clr_i_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign address   = address_reg;
    assign wb        = wb_reg;
    assign w         = w_reg;
    assign sp_dec    = sp_dec_reg;
    assign pc_load   = pc_load_reg;
    assign clr_i     = clr_i_reg;
    assign pc_vec    = pc_vec_reg;
    assign active_id = active_id_reg;

endmodule

// File: tb/tb_avr_intc.sv
// ---------------------------------------------------------------------------
// tb_avr_intc -- directed and randomized checks of avr_intc against a
// transaction-level reference model (sequence phase counter, pending set,
// quantum counter), one line printed per interrupt entry.
// ---------------------------------------------------------------------------
module tb_avr_intc;

    localparam int NIRQ = 8;
    localparam int PCW  = 16;
    localparam logic [7:0] EDGES = 8'hFE;

    logic            clock = 1'b0;
    logic            reset;
    logic [NIRQ-1:0] irq;
    logic            mask_we;
    logic [NIRQ-1:0] mask_wd;
    logic            quantum_we;
    logic [7:0]      quantum_wd;
    logic            tick;
    logic            boundary;
    logic            ie;
    logic [PCW-1:0]  pc_in;
    logic [15:0]     sp;
    logic            busy;
    logic [15:0]     address;
    logic [7:0]      wb;
    logic            w;
    logic            sp_dec;
    logic            pc_load;
    logic [PCW-1:0]  pc_vec;
    logic            clr_i;
    logic [NIRQ-1:0] pending;
    logic [3:0]      active_id;

    avr_intc dut (
        .clock      (clock),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wd    (mask_wd),
        .quantum_we (quantum_we),
        .quantum_wd (quantum_wd),
        .tick       (tick),
        .boundary   (boundary),
        .ie         (ie),
        .pc_in      (pc_in),
        .sp         (sp),
        .busy       (busy),
        .address    (address),
        .wb         (wb),
        .w          (w),
        .sp_dec     (sp_dec),
        .pc_load    (pc_load),
        .pc_vec     (pc_vec),
        .clr_i      (clr_i),
        .pending    (pending),
        .active_id  (active_id)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase counts cycles since the entry was accepted: 0 idle,
    // 1 low-byte push, 2 high-byte push, 3 vector load.
    bit [7:0]  m_epend, m_prev, m_mask;
    int        m_cnt, m_quant, m_phase, m_id, m_pcs, m_sps;
    bit [15:0] m_addr, m_vec;
    bit [7:0]  m_wb;

    task automatic m_reset();
        m_epend = 0; m_prev = 0; m_mask = 8'h01;
        m_cnt = 0; m_quant = 10; m_phase = 0; m_id = 0;
        m_pcs = 0; m_sps = 0; m_addr = 0; m_vec = 0; m_wb = 0;
    endtask

    function automatic logic [7:0] m_pending();
        logic [7:0] p;
        for (int n = 0; n < 8; n++) p[n] = EDGES[n] ? m_epend[n] : irq[n];
        if (m_quant != 0 && m_cnt >= m_quant) p[0] = 1'b1;
        return p;
    endfunction

    function automatic int m_take_id();
        logic [7:0] r;
        r = m_pending() & m_mask;
        if (m_phase != 0 || !boundary || !ie) return -1;
        for (int n = 0; n < 8; n++) if (r[n]) return n;
        return -1;
    endfunction

    task automatic m_clock();
        int t;
        int ph;
        t  = m_take_id();
        ph = m_phase;
        if (reset) begin
            m_reset();
            return;
        end
        for (int n = 0; n < 8; n++)
            if (EDGES[n])
                m_epend[n] = (irq[n] & ~m_prev[n]) | (m_epend[n] & !(ph == 1 && m_id == n));
        if (quantum_we || (ph == 1 && m_id == 0)) m_cnt = 0;
        else if (tick && ie && ph == 0 && m_cnt < 255) m_cnt++;
        if (mask_we) m_mask = mask_wd;
        if (quantum_we) m_quant = quantum_wd;
        case (ph)
            0: if (t >= 0) begin
                m_phase = 1; m_id = t; m_pcs = pc_in; m_sps = sp;
                m_addr = sp; m_wb = pc_in[7:0];
                $display("[TB] entry ch%0d pc=%04h sp=%04h t=%0t", t, pc_in, sp, $time);
            end
            1: begin
                m_phase = 2; m_addr = 16'(m_sps - 1); m_wb = 8'(m_pcs >> 8);
            end
            2: begin
                m_phase = 3; m_vec = 16'(2 + m_id * 2);
            end
            default: m_phase = 0;
        endcase
        m_prev = irq;
    endtask

    // One clock: check combinational outputs before the edge, advance the
    // model at the edge, check registered outputs on the falling edge.
    task automatic cyc();
        #1;
        chk("busy", 32'(busy), 32'(m_phase != 0 || m_take_id() >= 0));
        chk("pending", 32'(pending), 32'(m_pending()));
        @(posedge clock);
        m_clock();
        @(negedge clock);
        chk("w", 32'(w), 32'(m_phase == 1 || m_phase == 2));
        chk("sp_dec", 32'(sp_dec), 32'(m_phase == 1 || m_phase == 2));
        chk("pc_load", 32'(pc_load), 32'(m_phase == 3));
        chk("clr_i", 32'(clr_i), 32'(m_phase == 3));
        chk("address", 32'(address), 32'(m_addr));
        chk("wb", 32'(wb), 32'(m_wb));
        chk("pc_vec", 32'(pc_vec), 32'(m_vec));
        chk("active_id", 32'(active_id), 32'(m_id));
        mask_we = 0; quantum_we = 0; tick = 0;
    endtask

    initial begin
        int nw;
        reset = 1; irq = 0; mask_we = 0; mask_wd = 0; quantum_we = 0;
        quantum_wd = 0; tick = 0; boundary = 0; ie = 0; pc_in = 0; sp = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        m_reset();
        cyc();
        reset = 0;
        chk("rst_w", 32'(w), 0);
        chk("rst_address", 32'(address), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_active_id", 32'(active_id), 0);

        // 1: single edge channel entry with known push values
        mask_we = 1; mask_wd = 8'h04; cyc();
        ie = 1; irq = 8'h04; cyc();
        irq = 0;
        chk("t1_pend2_set", 32'(pending[2]), 1);
        boundary = 1; pc_in = 16'h0123; sp = 16'h045F; cyc();
        chk("t1_push_l_addr", 32'(address), 32'h045F);
        chk("t1_push_l_wb", 32'(wb), 32'h23);
        cyc();
        chk("t1_push_h_addr", 32'(address), 32'h045E);
        chk("t1_push_h_wb", 32'(wb), 32'h01);
        chk("t1_pend2_clr", 32'(pending[2]), 0);
        cyc();
        chk("t1_pc_load", 32'(pc_load), 1);
        chk("t1_pc_vec", 32'(pc_vec), 6);
        chk("t1_clr_i", 32'(clr_i), 1);
        cyc();

        // 2: two simultaneous edges, lowest index first
        boundary = 0; mask_we = 1; mask_wd = 8'hFF; cyc();
        irq = 8'h28; cyc();
        irq = 0; boundary = 1;
        repeat (3) cyc();
        chk("t2_first_vec", 32'(pc_vec), 8);
        chk("t2_ch5_waiting", 32'(pending[5]), 1);
        cyc();
        repeat (3) cyc();
        chk("t2_second_vec", 32'(pc_vec), 12);
        cyc();

        // 3: ie low holds the request, raising ie takes it at once
        ie = 0; irq = 8'h04; cyc();
        irq = 0; repeat (3) cyc();
        chk("t3_held", 32'(pending[2]), 1);
        ie = 1; #1;
        chk("t3_busy_on_ie", 32'(busy), 1);
        repeat (3) cyc();
        chk("t3_vec", 32'(pc_vec), 6);
        cyc();

        // 4: quantum timer on channel 0, then disabled
        boundary = 0; quantum_we = 1; quantum_wd = 8'd3; cyc();
        repeat (3) begin tick = 1; cyc(); end
        chk("t4_src0", 32'(pending), 32'h01);
        boundary = 1;
        repeat (3) cyc();
        chk("t4_vec", 32'(pc_vec), 2);
        chk("t4_cnt_cleared", 32'(pending[0]), 0);
        cyc();
        quantum_we = 1; quantum_wd = 0; cyc();
        nw = 0;
        repeat (300) begin tick = 1; cyc(); nw += int'(w); end
        chk("t4_never_taken", 32'(nw), 0);

        // 5: level channel 0 retaken, then reset in the middle of a push
        irq = 8'h01; cyc(); cyc();
        chk("t5_level_held", 32'(pending[0]), 1);
        cyc(); cyc();
        #1;
        chk("t5_retake", 32'(busy), 1);
        cyc(); cyc();
        reset = 1; boundary = 0; cyc();
        reset = 0;
        chk("t5_rst_w", 32'(w), 0);
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        irq = 8'h05; boundary = 1; cyc();
        irq = 8'h01; cyc(); cyc();
        chk("t5_mask_rst_vec", 32'(pc_vec), 2);
        chk("t5_ch2_masked", 32'(pending[2]), 1);
        cyc();

        // 6: randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            irq        = 8'($urandom) & 8'($urandom) & 8'($urandom);
            boundary   = 1'($urandom_range(0, 1));
            ie         = ($urandom_range(0, 3) != 0);
            tick       = ($urandom_range(0, 2) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wd    = 8'($urandom);
            quantum_we = ($urandom_range(0, 31) == 0);
            quantum_wd = 8'($urandom_range(0, 6));
            pc_in      = 16'($urandom);
            sp         = 16'($urandom);
            reset      = ($urandom_range(0, 149) == 0);
            cyc();
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avr_intc.md
Name: avr_intc

Overview:
- Multi-source vectored interrupt controller and entry sequencer for the AVR8 microcode core.
- Generalises the core's single hard-wired timeslice interrupt into N prioritised, maskable channels with per-channel edge or level mode.
- Channel 0 is OR-ed with a built-in programmable ms-quantum timer.
- On acceptance at an instruction boundary it takes the RAM bus, pushes the return PC (low byte, then high byte), then loads the vector PC and clears SREG.I.

Parameters:
NIRQ, 8, number of interrupt channels (2..16)
PCW, 16, program counter width (9..16)
VEC_BASE, 2, vector address of channel 0
VEC_STRIDE, 2, word distance between consecutive vectors
EDGE_MASK, 8'hFE, bit n=1: channel n rising-edge captured; 0: level
MASK_RST, 8'h01, reset value of the enable mask
QUANTUM_RST, 8'd10, reset value of the timeslice limit in ms ticks

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
irq  in  NIRQ  external request lines, synchronous to clock
mask_we  in  1  write strobe for enable mask
mask_wd  in  NIRQ  new enable mask
quantum_we  in  1  write strobe for timeslice limit
quantum_wd  in  8  new limit; 0 disables the quantum timer
tick  in  1  one-cycle 1 ms strobe
boundary  in  1  CPU is at tstate 0 with no skip pending
ie  in  1  SREG.I
pc_in  in  PCW  return address to save
sp  in  16  current stack pointer
busy  out  1  controller owns bus; CPU must hold
address  out  16  RAM address for push
wb  out  8  RAM write data
w  out  1  RAM write enable
sp_dec  out  1  CPU decrements SP at next edge
pc_load  out  1  CPU loads pc_vec at next edge
pc_vec  out  PCW  vector address
clr_i  out  1  CPU clears SREG.I at next edge
pending  out  NIRQ  pending status (before mask)
active_id  out  4  channel currently being serviced

Behaviour:
- Reset: FSM=IDLE; pending, counter, pc_save, sp_save, address, wb, pc_vec, active_id = 0; w, sp_dec, pc_load, clr_i = 0; mask=MASK_RST; quantum=QUANTUM_RST; irq history = 0. Reset mid-sequence aborts at once; no further writes.
- Edge channel: rising edge of irq[n] (irq & ~irq_d) sets pending[n]; cleared only when that channel is taken. Set and clear in the same cycle: set wins.
- Level channel: pending[n] = irq[n] live; never cleared by the controller.
- Quantum timer: 8-bit counter.
  - Increments on tick while ie=1 and FSM=IDLE; saturates at 255.
  - Sets src0 when quantum!=0 and counter>=quantum.
  - Cleared to 0 when channel 0 is taken or quantum_we fires.
  - pending[0] = captured/level irq[0] OR src0.
- mask_we/quantum_we take effect at the next edge; writes during a sequence do not affect the channel already latched.
- req = pending & mask. take = (FSM==IDLE) & boundary & ie & |req. Lowest index wins.
- busy = take | (FSM!=IDLE), combinational.
- FSM:
  - IDLE→PUSH_L on take. Latch id, pc_save=pc_in, sp_save=sp. Registered outputs become address=sp, wb=pc_in[7:0], w=1, sp_dec=1.
  - PUSH_L→PUSH_H unconditionally. address=sp_save-1 (mod 2^16), wb=pc_save[PCW-1:8] zero-extended, w=1, sp_dec=1. Clear pending[id] if edge channel; clear counter if id==0.
  - PUSH_H→VECT. w=0, sp_dec=0, pc_load=1, clr_i=1, pc_vec=VEC_BASE+id*VEC_STRIDE truncated to PCW.
  - VECT→IDLE. pc_load=0, clr_i=0.
- Entry latency: take cycle plus 3 cycles; next take is possible no earlier than the cycle after VECT.
- While busy, boundary and ie are ignored.
- w, sp_dec, pc_load and clr_i are each high for exactly the cycles listed above.
- active_id holds the last taken id until the next take.

Test Plan:
- Reset, mask=8'h04, EDGE ch2 pulse irq[2] one cycle, ie=1, boundary=1, pc_in=16'h0123, sp=16'h045F → w high 2 cycles: (045F,23) then (045E,01); pc_load with pc_vec=6; clr_i; pending[2]=0.
- irq[5] and irq[3] both pulsed, mask=8'hFF → ch3 taken first (pc_vec=8); ch5 stays pending and is taken at the next boundary after VECT (pc_vec=12).
- ie=0, irq[2] pulsed → no take, pending[2]=1 held; raise ie → take occurs same cycle boundary=1.
- quantum=3, ie=1, three tick strobes, mask[0]=1 → take ch0, pc_vec=2, counter returns 0; quantum=0 with 300 ticks → never taken.
- Level ch0 with irq[0] held high through a sequence → pending[0] stays 1, retake at the next eligible boundary; assert reset during PUSH_H → w=0 next cycle, busy=0, mask=8'h01.
